// File: rtl/pht_access_scheduler.sv
// rtl/pht_access_scheduler.sv - shares one single-port PHT RAM between lookups and queued counter updates
// Optional macro PHT_HAZARD_EN: hold lookups whose address aliases a queued update.
module pht_access_scheduler #(
  parameter int K      = 4,
  parameter int M      = 4,
  parameter int N      = 2,
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [K-1:0]               pred_index,
  output logic                       resp_valid,
  output logic                       resp_taken,
  output logic [M-1:0]               resp_bhr,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [K-1:0]               upd_index,
  input  logic [M-1:0]               upd_bhr,
  input  logic                       upd_taken,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [K+M-1:0]             mem_addr,
  output logic [N-1:0]               mem_wdata,
  input  logic [N-1:0]               mem_rdata,
  output logic [M-1:0]               bhr,
  output logic [$clog2(QDEPTH):0]    q_count
);
  localparam int A  = K + M;
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, PRED_RD, UPD_WB} state_t;

  state_t         r_state;
  logic [K-1:0]   r_q_index [QDEPTH];
  logic [M-1:0]   r_q_bhr   [QDEPTH];
  logic           r_q_taken [QDEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [M-1:0]   r_bhr, r_snap, r_resp_bhr;
  logic           r_resp_valid, r_resp_taken;

  logic           w_full, w_empty, w_push, w_pop, w_hazard;
  logic           w_issue_pred, w_issue_upd, w_head_taken;
  logic [M-1:0]   w_bhr_next;
  logic [A-1:0]   w_head_addr, w_pred_addr;
  logic [N-1:0]   w_sat;

  assign w_full       = (r_count == CW'(QDEPTH));
  assign w_empty      = (r_count == '0);
  assign w_push       = upd_valid && !w_full;
  assign w_pop        = (r_state == UPD_WB);
  assign w_head_addr  = {r_q_bhr[r_rd_ptr], r_q_index[r_rd_ptr]};
  assign w_head_taken = r_q_taken[r_rd_ptr];
  assign w_pred_addr  = {r_bhr, pred_index};

  generate
    if (M == 1) begin : g_bhr1
      assign w_bhr_next = upd_taken;
    end else begin : g_bhrn
      assign w_bhr_next = {r_bhr[M-2:0], upd_taken};
    end
  endgenerate

`ifdef PHT_HAZARD_EN
  always_comb begin
    logic [PW-1:0] off;
    w_hazard = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      off = PW'(i) - r_rd_ptr;
      if (({1'b0, off} < r_count) && ({r_q_bhr[i], r_q_index[i]} == w_pred_addr))
        w_hazard = 1'b1;
    end
  end
`else
  assign w_hazard = 1'b0;
`endif

  // A full queue always wins so updates can never be starved by a stream of lookups.
  assign w_issue_upd  = !reset && (r_state == IDLE) &&
                        (w_full || (!w_empty && (!pred_valid || w_hazard)));
  assign w_issue_pred = !reset && (r_state == IDLE) && !w_full && pred_valid && !w_hazard;

  always_comb begin
    if (w_head_taken)
      w_sat = (&mem_rdata) ? mem_rdata : mem_rdata + N'(1);
    else
      w_sat = (|mem_rdata) ? mem_rdata - N'(1) : mem_rdata;
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = w_head_addr;
    if (w_issue_pred) begin
      mem_en   = 1'b1;
      mem_addr = w_pred_addr;
    end else if (w_issue_upd) begin
      mem_en   = 1'b1;
    end else if (!reset && r_state == UPD_WB) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bhr        <= '0;
      r_snap       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_taken <= 1'b0;
      r_resp_bhr   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_push) begin
        r_q_index[r_wr_ptr] <= upd_index;
        r_q_bhr[r_wr_ptr]   <= upd_bhr;
        r_q_taken[r_wr_ptr] <= upd_taken;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
        r_bhr               <= w_bhr_next;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      case (r_state)
        IDLE: begin
          if (w_issue_pred) begin
            r_snap  <= r_bhr;
            r_state <= PRED_RD;
          end else if (w_issue_upd) begin
            r_state <= UPD_WB;
          end
        end
        PRED_RD: begin
          r_resp_valid <= 1'b1;
          r_resp_taken <= mem_rdata[N-1];
          r_resp_bhr   <= r_snap;
          r_state      <= IDLE;
        end
        UPD_WB:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_wdata  = w_sat;
  assign pred_ready = w_issue_pred;
  assign upd_ready  = !w_full;
  assign bhr        = r_bhr;
  assign q_count    = r_count;
  assign resp_valid = r_resp_valid;
  assign resp_taken = r_resp_taken;
  assign resp_bhr   = r_resp_bhr;
endmodule

// File: tb/tb_pht_access_scheduler.sv
// tb/tb_pht_access_scheduler.sv - scoreboard bench for pht_access_scheduler with a transaction-level PHT model
module tb_pht_access_scheduler;
  localparam int K = 4, M = 4, N = 2, QDEPTH = 4;
  localparam int A = K + M;

  logic clk, reset;
  logic pred_valid, pred_ready, resp_valid, resp_taken;
  logic [K-1:0] pred_index, upd_index;
  logic [M-1:0] resp_bhr, upd_bhr, bhr;
  logic upd_valid, upd_ready, upd_taken;
  logic mem_en, mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata, mem_rdata;
  logic [$clog2(QDEPTH):0] q_count;

  pht_access_scheduler #(.K(K), .M(M), .N(N), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_index(pred_index),
    .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_bhr(resp_bhr),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_bhr(upd_bhr), .upd_taken(upd_taken),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bhr(bhr), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] init_val(input int a);
    if (a == 'h03) return 2'b10;
    if (a == 'hA5) return 2'b11;
    if (a == 'h21) return 2'b00;
    return N'((a * 7 + (a >> 3)) & 3);
  endfunction

  function automatic logic [N-1:0] sat(input logic [N-1:0] v, input logic t);
    int x;
    x = int'(v) + (t ? 1 : -1);
    if (x < 0) x = 0;
    if (x > (1 << N) - 1) x = (1 << N) - 1;
    return N'(x);
  endfunction

  // Behavioural single-port RAM: registered read, write on strobe.
  logic [N-1:0] ram [2**A];
  initial begin
    for (int a = 0; a < 2**A; a++) ram[a] = init_val(a);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  typedef struct { logic [A-1:0] addr; logic [N-1:0] data; } wr_t;
  typedef struct { logic taken; logic [M-1:0] b; int due; } rs_t;
  wr_t wq[$];
  rs_t rq[$];
  logic [N-1:0] m_ram  [2**A];
  logic [N-1:0] m_pred [2**A];
  logic [M-1:0] m_bhr;
  int m_phase;
  int cyc;

  // Monitor: checks every cycle against the model, then commits model effects at the clock edge.
  initial begin
    int mcount, new_phase;
    bit hz, full, exp_upd, exp_pred, do_wr, do_enq, et;
    logic [A-1:0] ea, pa;
    for (int a = 0; a < 2**A; a++) begin m_ram[a] = init_val(a); m_pred[a] = init_val(a); end
    m_bhr = '0; m_phase = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      do_wr = 0; do_enq = 0; new_phase = 0; ea = '0; et = 0;
      if (!reset) begin
        mcount = wq.size();
        chk(q_count == mcount, "q_count", 32'(q_count), 32'(mcount));
        chk(upd_ready == (mcount < QDEPTH), "upd_ready", 32'(upd_ready), 32'(mcount < QDEPTH));
        chk(bhr == m_bhr, "bhr", 32'(bhr), 32'(m_bhr));
        if (rq.size() > 0 && rq[0].due == cyc) begin
          chk(resp_valid == 1'b1, "resp_valid", 32'(resp_valid), 1);
          chk(resp_taken == rq[0].taken, "resp_taken", 32'(resp_taken), 32'(rq[0].taken));
          chk(resp_bhr == rq[0].b, "resp_bhr", 32'(resp_bhr), 32'(rq[0].b));
          void'(rq.pop_front());
        end else begin
          chk(resp_valid == 1'b0, "resp_spurious", 32'(resp_valid), 0);
        end
        pa = {m_bhr, pred_index};
        if (m_phase == 1) begin
          chk(!mem_en && !pred_ready, "busy_after_lookup", 32'({mem_en, pred_ready}), 0);
        end else if (m_phase == 2) begin
          chk(mem_en && mem_we && !pred_ready, "wb_strobe", 32'({mem_en, mem_we, pred_ready}), 6);
          if (wq.size() > 0) begin
            chk(mem_addr == wq[0].addr, "wb_addr", 32'(mem_addr), 32'(wq[0].addr));
            chk(mem_wdata == wq[0].data, "wb_data", 32'(mem_wdata), 32'(wq[0].data));
            do_wr = 1;
          end
        end else begin
          hz = 0;
`ifdef PHT_HAZARD_EN
          foreach (wq[i]) if (wq[i].addr == pa) hz = 1;
`endif
          full     = (mcount == QDEPTH);
          exp_upd  = full || (mcount > 0 && (!pred_valid || hz));
          exp_pred = !full && pred_valid && !hz;
          chk(pred_ready == exp_pred, "pred_ready", 32'(pred_ready), 32'(exp_pred));
          chk(mem_en == (exp_upd || exp_pred), "mem_en", 32'(mem_en), 32'(exp_upd || exp_pred));
          if (exp_pred) begin
            chk(!mem_we && mem_addr == pa, "lookup_addr", 32'({mem_we, mem_addr}), 32'(pa));
            rq.push_back('{taken: m_ram[pa][N-1], b: m_bhr, due: cyc + 2});
            new_phase = 1;
          end else if (exp_upd) begin
            chk(!mem_we && mem_addr == wq[0].addr, "upd_rd_addr", 32'({mem_we, mem_addr}), 32'(wq[0].addr));
            new_phase = 2;
          end
        end
        if (upd_valid && mcount < QDEPTH) begin
          do_enq = 1; ea = {upd_bhr, upd_index}; et = upd_taken;
        end
      end
      @(posedge clk);
      if (reset) begin
        wq.delete(); rq.delete();
        m_bhr = '0; m_phase = 0;
        for (int a = 0; a < 2**A; a++) m_pred[a] = m_ram[a];
      end else begin
        if (do_wr) begin
          m_ram[wq[0].addr] = wq[0].data;
          void'(wq.pop_front());
        end
        if (do_enq) begin
          m_pred[ea] = sat(m_pred[ea], et);
          wq.push_back('{addr: ea, data: m_pred[ea]});
          m_bhr = {m_bhr[M-2:0], et};
        end
        m_phase = new_phase;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_upd(input logic [K-1:0] i, input logic [M-1:0] b, input logic t);
    bit ok = 0;
    upd_valid = 1; upd_index = i; upd_bhr = b; upd_taken = t;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (upd_ready) ok = 1;
    end
    @(posedge clk); #1;
    upd_valid = 0;
    chk(ok, "upd_accept", 32'(ok), 1);
  endtask

  task automatic send_pred(input logic [K-1:0] i);
    bit ok = 0;
    pred_valid = 1; pred_index = i;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (pred_ready) ok = 1;
    end
    @(posedge clk); #1;
    pred_valid = 0;
    chk(ok, "pred_accept", 32'(ok), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1; pred_valid = 0; pred_index = '0;
    upd_valid = 0; upd_index = '0; upd_bhr = '0; upd_taken = 0;
    repeat (3) tick();
    chk(q_count == 0 && bhr == 0, "rst_q_bhr", 32'({q_count, bhr}), 0);
    chk(!mem_en && !mem_we && !resp_valid, "rst_mem_resp", 32'({mem_en, mem_we, resp_valid}), 0);
    chk(upd_ready && !resp_taken && resp_bhr == 0, "rst_ready_resp", 32'({upd_ready, resp_taken, resp_bhr}), 32'h20);
    reset = 0;

    send_pred(4'd3);
    repeat (4) tick();
    send_upd(4'd5, 4'hA, 1'b1);
    send_upd(4'd1, 4'h2, 1'b0);
    repeat (8) tick();

    // Lookups held continuously while four updates arrive back-to-back.
    pred_valid = 1; pred_index = K'($urandom);
    for (int u = 0; u < 4; u++) send_upd(K'($urandom), M'($urandom), 1'($urandom));
    repeat (12) begin pred_index = K'($urandom); tick(); end
    pred_valid = 0;
    repeat (20) tick();

    for (int u = 0; u < 10; u++) send_upd(K'($urandom), M'($urandom), 1'(u % 2));
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (q_count == 0) found = 1;
    end
    chk(found, "wrap_drain", 32'(q_count), 0);
    chk(bhr == 4'b0101, "wrap_bhr", 32'(bhr), 32'h5);

    // Reset in a write-back cycle while three updates are still queued.
    tick();
    upd_valid = 1; upd_index = 4'd7; upd_bhr = 4'h3; upd_taken = 1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (mem_we && q_count == 3) found = 1;
    end
    chk(found, "rst_setup", 32'(found), 1);
    #1 reset = 1; upd_valid = 0;
    @(posedge clk); #1 reset = 0;
    #1;
    chk(q_count == 0 && bhr == 0, "midrst_q_bhr", 32'({q_count, bhr}), 0);
    chk(!mem_en && !resp_valid && upd_ready, "midrst_mem", 32'({mem_en, resp_valid, upd_ready}), 1);
    tick();

    send_upd(4'd3, 4'h0, 1'b0);
    send_pred(4'd3);
    repeat (6) tick();

    for (int c = 0; c < 400; c++) begin
      pred_valid = 1'($urandom % 2); pred_index = K'($urandom % 4);
      upd_valid  = ($urandom % 3) == 0; upd_index = K'($urandom % 4);
      upd_bhr    = M'($urandom % 4); upd_taken = 1'($urandom);
      tick();
    end
    pred_valid = 0; upd_valid = 0;
    repeat (40) tick();
    chk(wq.size() == 0, "end_updates_drained", 32'(wq.size()), 0);
    chk(rq.size() == 0, "end_resps_drained", 32'(rq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
